// File: rtl/instr_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  // Index width for a power-of-two set count.
  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
interface instr_cache_if #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned CNT_WIDTH         = 16
);
  logic                         req;
  logic [ADDRESS_WIDTH-1:0]     A;
  logic                         flush;
  logic [INSTRUCTION_WIDTH-1:0] RD;
  logic                         hit;
  logic                         stall;
  logic                         misalign;
  logic                         mem_req;
  logic [ADDRESS_WIDTH-1:0]     mem_addr;
  logic                         mem_ready;
  logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
  logic [CNT_WIDTH-1:0]         hit_count;
  logic [CNT_WIDTH-1:0]         miss_count;

  // Fetch stage plus backing memory, as seen from outside the cache.
  modport master (
    output req, A, flush, mem_ready, mem_rdata,
    input  RD, hit, stall, misalign, mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  req, A, flush, mem_ready, mem_rdata,
    output RD, hit, stall, misalign, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/instr_cache_array.sv
// Line storage: asynchronous read, synchronous write, single-cycle clear of all valid bits.
module icache_array
  import instr_cache_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned IDX_WIDTH  = 4,
  parameter int unsigned TAG_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clear,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  line_t lines_q [SETS];
  line_t lines_d [SETS];

  // Clear is applied after the write so a flush always wins.
  always_comb begin
    lines_d = lines_q;
    if (we) begin
      lines_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, data: wr_data};
    end
    if (clear) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        lines_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_q <= '{default: '0};
    end else begin
      lines_q <= lines_d;
    end
  end

  always_comb begin
    rd_valid = lines_q[rd_idx].valid;
    rd_tag   = lines_q[rd_idx].tag;
    rd_data  = lines_q[rd_idx].data;
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: combinational hit path, single-word refill FSM,
// flush with in-flight discard, and saturating hit/miss counters.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned SETS              = 16,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_cache_if.slave  bus
);

  localparam int unsigned IDX   = idx_bits(SETS);
  localparam int unsigned TAG_W = ADDRESS_WIDTH - IDX - 2;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                     mem_req_q, mem_req_d;
  logic                     discard_q, discard_d;
  logic [CNT_WIDTH-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]     miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]               idx;
  logic [TAG_W-1:0]             tag;
  logic                         line_valid;
  logic [TAG_W-1:0]             line_tag;
  logic [INSTRUCTION_WIDTH-1:0] line_data;
  logic                         misalign;
  logic                         lookup_hit;
  logic                         miss;
  logic                         install;

  assign idx = bus.A[IDX+1:2];
  assign tag = bus.A[ADDRESS_WIDTH-1:IDX+2];

  icache_array #(
    .SETS       (SETS),
    .IDX_WIDTH  (IDX),
    .TAG_WIDTH  (TAG_W),
    .DATA_WIDTH (INSTRUCTION_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .clear    (bus.flush),
    .we       (install),
    .wr_idx   (miss_addr_q[IDX+1:2]),
    .wr_tag   (miss_addr_q[ADDRESS_WIDTH-1:IDX+2]),
    .wr_data  (bus.mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mem_req_q   <= 1'b0;
      discard_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mem_req_q   <= mem_req_d;
      discard_q   <= discard_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    mem_req_d   = mem_req_q;
    discard_d   = discard_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lookup_hit && (hit_cnt_q != '1)) begin
          hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end
        // A flush in the same cycle suppresses the refill; fetch retries and misses again.
        if (miss && !bus.flush) begin
          state_d     = REFILL;
          miss_addr_d = {bus.A[ADDRESS_WIDTH-1:2], 2'b00};
          mem_req_d   = 1'b1;
          discard_d   = 1'b0;
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      REFILL: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
        end else if (bus.flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    misalign   = bus.req & (bus.A[1:0] != 2'b00);
    lookup_hit = bus.req & ~misalign & line_valid & (line_tag == tag);
    miss       = (state_q == IDLE) & bus.req & ~misalign & ~lookup_hit;
    install    = (state_q == REFILL) & bus.mem_ready & ~discard_q & ~bus.flush;

    bus.hit        = lookup_hit;
    bus.RD         = lookup_hit ? line_data : '0;
    bus.misalign   = misalign;
    bus.stall      = (state_q == REFILL) | (bus.req & ~misalign & ~lookup_hit);
    bus.mem_req    = mem_req_q;
    bus.mem_addr   = miss_addr_q;
    bus.hit_count  = hit_cnt_q;
    bus.miss_count = miss_cnt_q;
  end

endmodule
